// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: byte-stream loader for the FPGA fabric configuration.
//
// Accepts fixed-length packets on a valid/ready byte stream and applies them to a
// shadow copy of the configuration. A COMMIT packet copies every shadow region to
// the active outputs at once.
//
// Packet: byte0 = {target[2:0], op[1:0], addr[10:8]}, byte1 = addr[7:0], byte2 = data.
//   targets: 0 brb, 1 bsb, 2 lb, 3 left io, 4 right io, 5 top io, 6 bottom io, 7 invalid
//   ops:     0 WRBIT, 1 WRBYTE, 2 CLEAR, 3 COMMIT
//
// Optional feature: define CFG_LOADER_CHECKSUM_EN for 4-byte packets whose last byte
// must equal byte0 ^ byte1 ^ byte2; a mismatching packet is discarded with cfg_err.
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous active-high reset
//   cfg_data       configuration byte
//   cfg_valid      cfg_data valid
//   cfg_ready      loader can accept a byte (low while applying and in reset)
//   brbselect      active routing-block configuration (900 bits)
//   bsbselect      active switch-block configuration (1728 bits)
//   lbselect       active logic-block configuration (80 bits)
//   *ioselect      active IO configuration, 30 bits per side
//   busy           FSM is not idle
//   cfg_done       one-cycle pulse after a COMMIT is applied
//   cfg_err        one-cycle pulse after a packet is rejected
module fpga_cfg_loader (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    cfg_data,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   output logic [899:0]  brbselect,
   output logic [1727:0] bsbselect,
   output logic [79:0]   lbselect,
   output logic [29:0]   leftioselect,
   output logic [29:0]   rightioselect,
   output logic [29:0]   topioselect,
   output logic [29:0]   bottomioselect,
   output logic          busy,
   output logic          cfg_done,
   output logic          cfg_err
);

   // All seven regions live in one flat vector; region r starts at region_off(r).
   localparam int unsigned TotalBits = 2828;

   localparam logic [1:0] OpWrBit  = 2'd0;
   localparam logic [1:0] OpWrByte = 2'd1;
   localparam logic [1:0] OpClear  = 2'd2;
   localparam logic [1:0] OpCommit = 2'd3;

`ifdef CFG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StAddr  = 3'd1,
      StData  = 3'd2,
      StChk   = 3'd3,
      StApply = 3'd4
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StAddr  = 3'd1,
      StData  = 3'd2,
      StApply = 3'd4
   } state_e;
`endif

   function automatic int unsigned region_size(input logic [2:0] t);
      case (t)
         3'd0:    return 900;
         3'd1:    return 1728;
         3'd2:    return 80;
         3'd7:    return 0;
         default: return 30;
      endcase
   endfunction

   function automatic int unsigned region_off(input logic [2:0] t);
      case (t)
         3'd0:    return 0;
         3'd1:    return 900;
         3'd2:    return 2628;
         3'd3:    return 2708;
         3'd4:    return 2738;
         3'd5:    return 2768;
         default: return 2798;
      endcase
   endfunction

   state_e                 state_q;
   logic [7:0]             byte0_q;
   logic [7:0]             byte1_q;
   logic [7:0]             data_q;
   logic [TotalBits-1:0]   shadow_q;
   logic [TotalBits-1:0]   shadow_d;
   logic [TotalBits-1:0]   active_q;
   logic                   done_q;
   logic                   err_q;

   logic [2:0]             tgt;
   logic [1:0]             op;
   logic [10:0]            addr;
   int unsigned            addr_int;
   logic                   pkt_ok;
   logic                   pkt_err;
   logic [11:0]            bit_idx;

   assign tgt  = byte0_q[7:5];
   assign op   = byte0_q[4:3];
   assign addr = {byte0_q[2:0], byte1_q};

`ifdef CFG_LOADER_CHECKSUM_EN
   logic chk_ok_q;
   assign pkt_ok = chk_ok_q;
`else
   assign pkt_ok = 1'b1;
`endif

   // Rejection rules; COMMIT can only fail on a bad checksum.
   always_comb begin
      addr_int = {21'd0, addr};
      pkt_err  = 1'b0;
      if (!pkt_ok) begin
         pkt_err = 1'b1;
      end else if (op != OpCommit) begin
         if (tgt == 3'd7) begin
            pkt_err = 1'b1;
         end else if (op != OpClear && addr_int >= region_size(tgt)) begin
            pkt_err = 1'b1;
         end
      end
   end

   // Next shadow contents for a write/clear packet. WRBYTE bits past the region end
   // simply find no matching bit position and are dropped.
   always_comb begin
      shadow_d = shadow_q;
      bit_idx  = '0;
      for (int unsigned r = 0; r < 7; r++) begin
         if (tgt == 3'(r)) begin
            for (int unsigned k = 0; k < region_size(3'(r)); k++) begin
               bit_idx = 12'(region_off(3'(r)) + k);
               case (op)
                  OpWrBit: begin
                     if (k == addr_int) shadow_d[bit_idx] = data_q[0];
                  end
                  OpWrByte: begin
                     if (k >= addr_int && k < addr_int + 8) begin
                        shadow_d[bit_idx] = data_q[3'(k - addr_int)];
                     end
                  end
                  OpClear: shadow_d[bit_idx] = 1'b0;
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         byte0_q  <= '0;
         byte1_q  <= '0;
         data_q   <= '0;
         shadow_q <= '0;
         active_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
         chk_ok_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (cfg_valid) begin
                  byte0_q <= cfg_data;
                  state_q <= StAddr;
               end
            end
            StAddr: begin
               if (cfg_valid) begin
                  byte1_q <= cfg_data;
                  state_q <= StData;
               end
            end
            StData: begin
               if (cfg_valid) begin
                  data_q  <= cfg_data;
`ifdef CFG_LOADER_CHECKSUM_EN
                  state_q <= StChk;
`else
                  state_q <= StApply;
`endif
               end
            end
`ifdef CFG_LOADER_CHECKSUM_EN
            StChk: begin
               if (cfg_valid) begin
                  chk_ok_q <= (cfg_data == (byte0_q ^ byte1_q ^ data_q));
                  state_q  <= StApply;
               end
            end
`endif
            StApply: begin
               state_q <= StIdle;
               if (pkt_err) begin
                  err_q <= 1'b1;
               end else if (op == OpCommit) begin
                  active_q <= shadow_q;
                  done_q   <= 1'b1;
               end else begin
                  shadow_q <= shadow_d;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cfg_ready      = (state_q != StApply) && !reset;
   assign busy           = (state_q != StIdle);
   assign cfg_done       = done_q;
   assign cfg_err        = err_q;

   assign brbselect      = active_q[899:0];
   assign bsbselect      = active_q[2627:900];
   assign lbselect       = active_q[2707:2628];
   assign leftioselect   = active_q[2737:2708];
   assign rightioselect  = active_q[2767:2738];
   assign topioselect    = active_q[2797:2768];
   assign bottomioselect = active_q[2827:2798];

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader: directed scenarios plus random packets
// checked against a bit-array model of the shadow and active configuration.
module tb_fpga_cfg_loader;

`ifdef CFG_LOADER_CHECKSUM_EN
   localparam int unsigned PktLen = 4;
`else
   localparam int unsigned PktLen = 3;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    cfg_data = '0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [899:0]  brbselect;
   logic [1727:0] bsbselect;
   logic [79:0]   lbselect;
   logic [29:0]   leftioselect;
   logic [29:0]   rightioselect;
   logic [29:0]   topioselect;
   logic [29:0]   bottomioselect;
   logic          busy;
   logic          cfg_done;
   logic          cfg_err;

   fpga_cfg_loader dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_data       (cfg_data),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .brbselect      (brbselect),
      .bsbselect      (bsbselect),
      .lbselect       (lbselect),
      .leftioselect   (leftioselect),
      .rightioselect  (rightioselect),
      .topioselect    (topioselect),
      .bottomioselect (bottomioselect),
      .busy           (busy),
      .cfg_done       (cfg_done),
      .cfg_err        (cfg_err)
   );

   always #5 clk = ~clk;

   int unsigned   n_checks = 0;
   int unsigned   n_fail = 0;
   int unsigned   step_cnt = 0;
   int unsigned   ready_low_cnt = 0;
   logic          pend_done = 1'b0;
   logic          pend_err = 1'b0;
   logic [1727:0] sh_m [7];
   logic [1727:0] act_m [7];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic finish_test();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   function automatic int unsigned rsize(input logic [2:0] t);
      case (t)
         3'd0:    return 900;
         3'd1:    return 1728;
         3'd2:    return 80;
         default: return 30;
      endcase
   endfunction

   task automatic check_outputs();
      check_eq("brb_diff_bits", 32'($countones(brbselect ^ act_m[0][899:0])), 0);
      check_eq("bsb_diff_bits", 32'($countones(bsbselect ^ act_m[1])), 0);
      check_eq("lb_diff_bits", 32'($countones(lbselect ^ act_m[2][79:0])), 0);
      check_eq("left_io", 32'(leftioselect), 32'(act_m[3][29:0]));
      check_eq("right_io", 32'(rightioselect), 32'(act_m[4][29:0]));
      check_eq("top_io", 32'(topioselect), 32'(act_m[5][29:0]));
      check_eq("bottom_io", 32'(bottomioselect), 32'(act_m[6][29:0]));
   endtask

   // Advance one cycle, then check pulses and active outputs against the model.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      step_cnt++;
      if (!cfg_ready && !reset) ready_low_cnt++;
      check_eq("cfg_done", 32'(cfg_done), 32'(pend_done));
      check_eq("cfg_err", 32'(cfg_err), 32'(pend_err));
      check_eq("done_err_excl", 32'(cfg_done & cfg_err), 0);
      pend_done = 1'b0;
      pend_err  = 1'b0;
      check_outputs();
   endtask

   task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input bit ok);
      logic [2:0]  t;
      logic [1:0]  op;
      int unsigned a;
      t  = b0[7:5];
      op = b0[4:3];
      a  = {21'd0, b0[2:0], b1};
      if (!ok) begin
         pend_err = 1'b1;
      end else if (op == 2'd3) begin
         for (int r = 0; r < 7; r++) act_m[r] = sh_m[r];
         pend_done = 1'b1;
      end else if (t == 3'd7) begin
         pend_err = 1'b1;
      end else if (op == 2'd2) begin
         sh_m[t] = '0;
      end else if (a >= rsize(t)) begin
         pend_err = 1'b1;
      end else if (op == 2'd0) begin
         sh_m[t][11'(a)] = b2[0];
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (a + 32'(i) < rsize(t)) sh_m[t][11'(a + 32'(i))] = b2[3'(i)];
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      int unsigned waits;
      if (gap != 0) begin
         cfg_valid = 1'b0;
         repeat (gap) step();
      end
      cfg_data  = b;
      cfg_valid = 1'b1;
      waits = 0;
      while (!cfg_ready) begin
         step();
         waits++;
         if (waits > 8) begin
            check_eq("ready_timeout", waits, 0);
            finish_test();
         end
      end
      step();
   endtask

   // chk_flip = 0 sends a correct checksum byte in the checksum build.
   task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] chk_flip, input int unsigned gap_max,
                              input bit b2b);
      bit ok;
      send_byte(b0, $urandom_range(0, gap_max));
      check_eq("busy_mid_packet", 32'(busy), 1);
      send_byte(b1, $urandom_range(0, gap_max));
      send_byte(b2, $urandom_range(0, gap_max));
`ifdef CFG_LOADER_CHECKSUM_EN
      send_byte(b0 ^ b1 ^ b2 ^ chk_flip, $urandom_range(0, gap_max));
      ok = (chk_flip == 8'h00);
`else
      ok = 1'b1;
      if (chk_flip != 8'h00) ok = 1'b1;
`endif
      check_eq("apply_ready_low", 32'(cfg_ready), 0);
      check_eq("apply_busy", 32'(busy), 1);
      if (!b2b) cfg_valid = 1'b0;
      model_apply(b0, b1, b2, ok);
   endtask

   task automatic do_reset(input int unsigned cycles);
      reset     = 1'b1;
      cfg_valid = 1'b0;
      for (int r = 0; r < 7; r++) begin
         sh_m[r]  = '0;
         act_m[r] = '0;
      end
      pend_done = 1'b0;
      pend_err  = 1'b0;
      repeat (cycles) begin
         step();
         check_eq("reset_ready", 32'(cfg_ready), 0);
         check_eq("reset_busy", 32'(busy), 0);
      end
      reset = 1'b0;
      #1;
      check_eq("release_ready", 32'(cfg_ready), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  tgt;
      logic [1:0]  op;
      logic [10:0] addr;
      logic [7:0]  b0;
      logic [7:0]  flip;
      int unsigned sz;
      int unsigned s0;
      int unsigned r0;

      do_reset(3);

      // WRBIT brb[5]=1 stays in shadow until COMMIT.
      send_packet(8'h00, 8'h05, 8'h01, 8'h00, 0, 1'b0);
      step();
      check_eq("r030_before_commit", 32'(brbselect[5]), 0);
      send_packet(8'h18, 8'h00, 8'h00, 8'h00, 0, 1'b0);
      step();
      check_eq("r030_after_commit", 32'(brbselect[5]), 1);

      // WRBYTE lb at 76: bits 76..79 written, rest dropped, no error.
      send_packet(8'h48, 8'h4C, 8'hFF, 8'h00, 1, 1'b0);
      step();
      send_packet(8'h18, 8'h00, 8'h00, 8'h00, 0, 1'b0);
      step();
      check_eq("r031_lb_top", 32'(lbselect[79:76]), 32'hF);

      // WRBIT bsb at 1728 is out of range.
      send_packet(8'h26, 8'hC0, 8'h01, 8'h00, 0, 1'b0);
      step();
      send_packet(8'h18, 8'h00, 8'h00, 8'h00, 0, 1'b0);
      step();
      check_eq("r032_bsb_ones", 32'($countones(bsbselect)), 0);

      // Reset mid-packet discards it.
      send_byte(8'hA0, 0);
      send_byte(8'h03, 0);
      do_reset(2);
      send_packet(8'h18, 8'h00, 8'h00, 8'h00, 0, 1'b0);
      step();
      check_eq("r033_top_zero", 32'(topioselect), 0);
      check_eq("r033_brb_cleared", 32'(brbselect[5]), 0);

`ifdef CFG_LOADER_CHECKSUM_EN
      send_packet(8'h20, 8'h07, 8'h01, 8'h00, 0, 1'b0);
      step();
      send_packet(8'h18, 8'h00, 8'h00, 8'h19, 0, 1'b0);
      step();
      check_eq("r035_bad_chk_bsb", 32'(bsbselect[7]), 0);
      send_packet(8'h18, 8'h00, 8'h00, 8'h00, 0, 1'b0);
      step();
      check_eq("r035_good_chk_bsb", 32'(bsbselect[7]), 1);
`endif

      // Random packets with random idle gaps and occasional mid-packet resets.
      for (int n = 0; n < 250; n++) begin
         tgt = 3'($urandom_range(0, 7));
         op  = 2'($urandom_range(0, 3));
         sz  = (tgt == 3'd7) ? 30 : rsize(tgt);
         case ($urandom_range(0, 2))
            0:       addr = 11'($urandom_range(0, 2047));
            1:       addr = 11'(sz - 1 - $urandom_range(0, 9));
            default: addr = 11'(sz - 8 + $urandom_range(0, 16));
         endcase
         b0   = {tgt, op, addr[10:8]};
         flip = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         if ($urandom_range(0, 40) == 0) begin
            send_byte(b0, 0);
            send_byte(addr[7:0], 0);
            do_reset(1);
         end else begin
            send_packet(b0, addr[7:0], 8'($urandom), flip, 2, 1'b0);
         end
      end
      step();

      // Continuous stream: cfg_ready low exactly one cycle per packet.
      s0 = step_cnt;
      r0 = ready_low_cnt;
      for (int n = 0; n < 8; n++) begin
         tgt = 3'($urandom_range(0, 6));
         op  = (n % 3 == 2) ? 2'd3 : 2'($urandom_range(0, 1));
         addr = 11'($urandom_range(0, rsize(tgt) - 1));
         send_packet({tgt, op, addr[10:8]}, addr[7:0], 8'($urandom), 8'h00, 0, (n != 7));
      end
      check_eq("b2b_ready_low_cycles", ready_low_cnt - r0, 8);
      check_eq("b2b_total_cycles", step_cnt - s0, PktLen * 8 + 7);
      step();
      step();
      check_eq("final_idle", 32'(busy), 0);

      finish_test();
   end

endmodule
